out_display: RTL and testbench

//  Output register with a decimal 7-segment front end. It latches the bus value
//  on an OUT instruction, exactly as the plain output register does.
//  It converts the latched value to packed BCD with a sequential double-dabble

---
 rtl/out_display_if.sv | 42 ++++
 rtl/out_display.sv | 197 +++++++++++++++++++
 tb/tb_out_display.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/out_display_if.sv
// out_display_if
//   Bus bundle between the CPU side (master) and the decimal output
//   register (slave).
//
//   Load handshake: i_load_enable is a strobe that the slave qualifies
//   with its clk_en input.  There is no ready line.  A qualified strobe is
//   always accepted on that clk edge, even in the middle of a conversion.
//   In that case the conversion restarts with the new value.  Every other
//   signal is a plain registered status or display output.
//
//   Signals
//     i_load_enable  master->slave  load request (OUT control line)
//     i_load_data    master->slave  bus value to latch
//     o_data         slave->master  latched binary value
//     o_busy         slave->master  conversion in progress
//     o_bcd          slave->master  packed BCD of the last finished conversion
//     o_seg          slave->master  segments {g,f,e,d,c,b,a} of the scanned digit
//     o_an           slave->master  one-hot digit select
//     o_dbg_state    slave->master  converter FSM state (0 idle, 1 shift)
interface out_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  i_load_enable;
    logic [WIDTH-1:0]      i_load_data;
    logic [WIDTH-1:0]      o_data;
    logic                  o_busy;
    logic [4*DIGITS-1:0]   o_bcd;
    logic [6:0]            o_seg;
    logic [DIGITS-1:0]     o_an;
    logic                  o_dbg_state;

    modport master (
        output i_load_enable, i_load_data,
        input  o_data, o_busy, o_bcd, o_seg, o_an, o_dbg_state
    );

    modport slave (
        input  i_load_enable, i_load_data,
        output o_data, o_busy, o_bcd, o_seg, o_an, o_dbg_state
    );
endinterface

// File: rtl/out_display.sv
// out_display
//   Output register with a decimal 7-segment front end.  An OUT
//   instruction (i_load_enable qualified by clk_en) latches the bus value.
//   A sequential double-dabble engine then converts the value to packed
//   BCD, one bit per clk.  The BCD digits are time-multiplexed onto a
//   common-bus 7-segment display.  Conversion and scanning run on every
//   clk, so the display stays live while the CPU is halted.
//
//   Ports
//     clk      system clock
//     i_rst_n  synchronous active-low reset
//     clk_en   CPU clock enable; it qualifies loads only
//     bus      out_display_if.slave.  It carries load strobe and data,
//              latched value, busy, BCD, segments, anodes and FSM state.
module out_display #(
    parameter int WIDTH          = 8,
    parameter int DIGITS         = 3,
    parameter int SCAN_DIV       = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          clk_en,
    out_display_if.slave  bus
);
    localparam int BW = 4 * DIGITS;                      // BCD field width
    localparam int SW = BW + WIDTH;                      // shift register width
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // This is ceil(WIDTH * log10(2)) in fixed point.
    localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;

    localparam logic [6:0]        SEG_RST = SEG_ACTIVE_LOW ? ~7'h3F : 7'h3F;
    localparam logic [DIGITS-1:0] AN_ONE  = DIGITS'(1);
    localparam logic [DIGITS-1:0] AN_RST  = SEG_ACTIVE_LOW ? ~AN_ONE : AN_ONE;

    if (DIGITS < MIN_DIGITS) begin : g_bad_digits
        $error("out_display: DIGITS too small for WIDTH");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("out_display: SCAN_DIV must be >= 2");
    end

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic              load;
    logic              busy;
    logic              last_shift;
    logic [SW-1:0]     adj;
    logic [SW-1:0]     shifted;
    logic [3:0]        nib;
    logic              hi_zero;
    logic [6:0]        seg_raw;
    logic [DIGITS-1:0] an_raw;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign load       = clk_en & bus.i_load_enable;
    assign last_shift = (cnt_q == CW'(WIDTH - 1));

    // ---------------- converter FSM ----------------
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (load)            state_d = ST_SHIFT;   // restart
                else if (last_shift) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_SHIFT);
    end

    // ---------------- double-dabble datapath ----------------
    always_comb begin
        adj = sr_q;
        // The +3 adjust is applied before the shift, so a digit >= 5
        // carries into the next digit when it doubles.
        for (int d = 0; d < DIGITS; d++) begin
            if (sr_q[WIDTH + 4*d +: 4] >= 4'd5) begin
                adj[WIDTH + 4*d +: 4] = sr_q[WIDTH + 4*d +: 4] + 4'd3;
            end
        end
        shifted = {adj[SW-2:0], 1'b0};

        data_d = data_q;
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        bcd_d  = bcd_q;
        if (load) begin
            data_d = bus.i_load_data;
            sr_d   = {{BW{1'b0}}, bus.i_load_data};
            cnt_d  = '0;
        end else if (state_q == ST_SHIFT) begin
            sr_d  = shifted;
            cnt_d = cnt_q + CW'(1);
            // o_bcd only takes the finished field, so partial values are
            // never visible.
            if (last_shift) bcd_d = shifted[SW-1:WIDTH];
        end
    end

    // ---------------- digit scan ----------------
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    always_comb begin
        nib     = '0;
        hi_zero = 1'b1;
        an_raw  = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (IW'(d) == idx_q) begin
                nib       = bcd_q[4*d +: 4];
                an_raw[d] = 1'b1;
            end
            // The digit is a leading zero when it and every digit above it are zero.
            if (d >= int'(idx_q) && bcd_q[4*d +: 4] != 4'd0) hi_zero = 1'b0;
        end
        seg_raw = seg7(nib);
        if (BLANK_LZ && idx_q != '0 && hi_zero) seg_raw = 7'h00;
        seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        an_d  = SEG_ACTIVE_LOW ? ~an_raw  : an_raw;
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            bcd_q   <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_RST;
            an_q    <= AN_RST;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            bcd_q   <= bcd_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_busy      = busy;
    assign bus.o_bcd       = bcd_q;
    assign bus.o_seg       = seg_q;
    assign bus.o_an        = an_q;
    assign bus.o_dbg_state = state_q;
endmodule

// File: tb/tb_out_display.sv
module tb_out_display;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic       le;
    logic [7:0] ld;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state for the random phase.
    logic [11:0] exp_q[$];
    logic [11:0] cur_exp;
    logic [7:0]  last_data;
    logic        pending;
    int          pend_cnt;

    always #5 clk = ~clk;

    out_display_if #(.WIDTH(8), .DIGITS(3)) if0 ();
    out_display_if #(.WIDTH(8), .DIGITS(3)) if1 ();
    out_display_if #(.WIDTH(8), .DIGITS(3)) if2 ();

    assign if0.i_load_enable = le;
    assign if0.i_load_data   = ld;
    assign if1.i_load_enable = le;
    assign if1.i_load_data   = ld;
    assign if2.i_load_enable = le;
    assign if2.i_load_data   = ld;

    out_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1))
        dut (.clk(clk), .i_rst_n(rst_n), .clk_en(ce), .bus(if0));
    out_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0))
        dut_nb (.clk(clk), .i_rst_n(rst_n), .clk_en(ce), .bus(if1));
    out_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1))
        dut_al (.clk(clk), .i_rst_n(rst_n), .clk_en(ce), .bus(if2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Drive one cycle of random-phase stimulus, advance the model and compare.
    task automatic model_step(input logic ce_v, input logic le_v, input logic [7:0] ld_v);
        logic [6:0] s_inv;
        logic [2:0] a_inv;
        ce = ce_v;
        le = le_v;
        ld = ld_v;
        tick();
        if (ce_v && le_v) begin
            exp_q.delete();
            exp_q.push_back(to_bcd(int'(ld_v)));
            last_data = ld_v;
            pending   = 1'b1;
            pend_cnt  = 0;
        end else if (pending) begin
            pend_cnt++;
            if (pend_cnt == 8) begin
                cur_exp = exp_q.pop_front();
                pending = 1'b0;
            end
        end
        check("rnd_bcd", if0.o_bcd, cur_exp);
        check("rnd_busy", if0.o_busy, pending);
        check("rnd_data", if0.o_data, last_data);
        check("rnd_al_bcd", if2.o_bcd, cur_exp);
        s_inv = ~if0.o_seg;
        a_inv = ~if0.o_an;
        check("rnd_al_seg", if2.o_seg, s_inv);
        check("rnd_al_an", if2.o_an, a_inv);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       found;
        logic [2:0] prev_an;
        logic [2:0] exp_an;
        logic [2:0] exp_an_inv;
        logic [6:0] exp_seg;
        logic [6:0] exp_seg_nb;
        logic [6:0] exp_seg_inv;
        int         n_loads;
        int         cyc;
        logic       ce_r;
        logic       le_r;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        ce    = 1'b0;
        le    = 1'b0;
        ld    = 8'h00;
        repeat (3) tick();
        check("rst_data", if0.o_data, 8'h00);
        check("rst_bcd", if0.o_bcd, 12'h000);
        check("rst_busy", if0.o_busy, 1'b0);
        check("rst_an", if0.o_an, 3'b001);
        check("rst_seg", if0.o_seg, 7'h3F);
        check("rst_al_an", if2.o_an, 3'b110);
        check("rst_al_seg", if2.o_seg, 7'h40);

        // ---------------- load FF ----------------
        rst_n = 1'b1;
        ce    = 1'b1;
        le    = 1'b1;
        ld    = 8'hFF;
        tick();
        le = 1'b0;
        check("ff_data", if0.o_data, 8'hFF);
        check("ff_busy0", if0.o_busy, 1'b1);
        for (int k = 1; k < 8; k++) begin
            tick();
            check("ff_busy", if0.o_busy, 1'b1);
            check("ff_bcd_hold", if0.o_bcd, 12'h000);
        end
        tick();
        check("ff_bcd", if0.o_bcd, 12'h255);
        check("ff_done", if0.o_busy, 1'b0);

        // ---------------- halted CPU: no load ----------------
        ce = 1'b0;
        le = 1'b1;
        ld = 8'h55;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("halt_data", if0.o_data, 8'hFF);
            check("halt_bcd", if0.o_bcd, 12'h255);
            check("halt_busy", if0.o_busy, 1'b0);
        end
        le = 1'b0;
        ce = 1'b1;

        // ---------------- restart mid-conversion ----------------
        le = 1'b1;
        ld = 8'h80;
        tick();
        le = 1'b0;
        check("rs_bcd_a", if0.o_bcd, 12'h255);
        tick();
        check("rs_bcd_b", if0.o_bcd, 12'h255);
        tick();
        check("rs_bcd_c", if0.o_bcd, 12'h255);
        le = 1'b1;
        ld = 8'h2A;
        tick();
        le = 1'b0;
        check("rs_data", if0.o_data, 8'h2A);
        for (int k = 1; k < 8; k++) begin
            tick();
            check("rs_bcd_hold", if0.o_bcd, 12'h255);
            check("rs_busy", if0.o_busy, 1'b1);
        end
        tick();
        check("rs_bcd", if0.o_bcd, 12'h042);
        check("rs_done", if0.o_busy, 1'b0);

        // ---------------- scan and blanking ----------------
        le = 1'b1;
        ld = 8'h07;
        tick();
        le = 1'b0;
        repeat (8) tick();
        check("scan_bcd", if0.o_bcd, 12'h007);
        found   = 1'b0;
        prev_an = if0.o_an;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (prev_an != 3'b001 && if0.o_an == 3'b001) found = 1'b1;
            prev_an = if0.o_an;
        end
        check("scan_sync", found, 1'b1);
        for (int t = 0; t < 12; t++) begin
            exp_an      = 3'b001 << (t / 4);
            exp_an_inv  = ~exp_an;
            exp_seg     = (t < 4) ? 7'h07 : 7'h00;
            exp_seg_nb  = (t < 4) ? 7'h07 : 7'h3F;
            exp_seg_inv = ~exp_seg;
            check("scan_an", if0.o_an, exp_an);
            check("scan_seg", if0.o_seg, exp_seg);
            check("scan_nb_an", if1.o_an, exp_an);
            check("scan_nb_seg", if1.o_seg, exp_seg_nb);
            check("scan_al_an", if2.o_an, exp_an_inv);
            check("scan_al_seg", if2.o_seg, exp_seg_inv);
            if (t < 11) tick();
        end

        // ---------------- reset during conversion ----------------
        le = 1'b1;
        ld = 8'hC8;
        tick();
        le = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("ra_bcd", if0.o_bcd, 12'h000);
        check("ra_busy", if0.o_busy, 1'b0);
        check("ra_data", if0.o_data, 8'h00);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("ra_bcd_hold", if0.o_bcd, 12'h000);
            check("ra_busy_hold", if0.o_busy, 1'b0);
        end

        // ---------------- random loads ----------------
        cur_exp   = 12'h000;
        last_data = 8'h00;
        pending   = 1'b0;
        pend_cnt  = 0;
        n_loads   = 0;
        cyc       = 0;
        while (n_loads < 500 && cyc < 20000) begin
            ce_r = ($urandom_range(0, 4) != 0);
            le_r = ($urandom_range(0, 7) == 0);
            model_step(ce_r, le_r, 8'($urandom_range(0, 255)));
            if (ce_r && le_r) n_loads++;
            cyc++;
        end
        check("rnd_loads", n_loads, 500);
        for (int k = 0; k < 10; k++) model_step(1'b1, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
